// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data port share one
// fixed-latency memory, one transaction in flight at a time.
module mem_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_valid,
  output logic        if_stall,
  input  logic [1:0]  dm_command,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wr_data,
  output logic [31:0] dm_rd_data,
  output logic        dm_done,
  output logic        dm_stall,
  output logic [1:0]  mem_command,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, I_BUSY = 2'd1, D_BUSY = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [SW-1:0] d_streak, d_streak_nxt;
  logic [31:0]   lat_addr, lat_addr_nxt;
  logic [31:0]   lat_wdata, lat_wdata_nxt;
  logic          lat_store, lat_store_nxt;
  logic          dm_pend;
  logic          grant_d;
  logic          grant_i;
  logic          done;

  // Handshake: a requester holds its request until its one-cycle done pulse;
  // the arbiter samples address/data only in the grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      d_streak  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_store <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      d_streak  <= d_streak_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
      lat_store <= lat_store_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    d_streak_nxt  = d_streak;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    lat_store_nxt = lat_store;
    dm_pend       = (dm_command == CMD_LOAD) || (dm_command == CMD_STORE);
    grant_d       = 1'b0;
    grant_i       = 1'b0;
    done          = 1'b0;
    mem_command   = CMD_NONE;
    mem_addr      = lat_addr;
    mem_wr_data   = lat_wdata;
    if_valid      = 1'b0;
    if_data       = '0;
    dm_done       = 1'b0;
    dm_rd_data    = '0;

    if (!rst) begin
      case (state)
        IDLE: begin
          // Data wins ties unless the fetch has been passed over too often.
          grant_d = dm_pend && !(if_req && (d_streak == SW'(MAX_D_STREAK)));
          grant_i = if_req && !grant_d;
          if (grant_d) begin
            mem_command   = dm_command;
            mem_addr      = dm_addr;
            mem_wr_data   = dm_wr_data;
            lat_addr_nxt  = dm_addr;
            lat_wdata_nxt = dm_wr_data;
            lat_store_nxt = (dm_command == CMD_STORE);
            cnt_nxt       = 4'(MEM_LATENCY - 1);
            state_nxt     = D_BUSY;
            if (!if_req)
              d_streak_nxt = '0;
            else if (d_streak != SW'(MAX_D_STREAK))
              d_streak_nxt = d_streak + 1'b1;
          end else if (grant_i) begin
            mem_command   = CMD_LOAD;
            mem_addr      = if_addr;
            mem_wr_data   = '0;
            lat_addr_nxt  = if_addr;
            lat_wdata_nxt = '0;
            lat_store_nxt = 1'b0;
            cnt_nxt       = 4'(MEM_LATENCY - 1);
            state_nxt     = I_BUSY;
            d_streak_nxt  = '0;
          end
        end
        I_BUSY, D_BUSY: begin
          if (cnt == '0) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
          if (state == I_BUSY) begin
            if_valid = done;
            if_data  = done ? mem_rd_data : '0;
          end else begin
            dm_done    = done;
            dm_rd_data = (done && !lat_store) ? mem_rd_data : '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if_stall = !rst && if_req && !if_valid;
    dm_stall = !rst && dm_pend && !dm_done;
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, every cycle
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int L    = 2;
  localparam int MAXD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_valid;
  logic        if_stall;
  logic [1:0]  dm_command;
  logic [31:0] dm_addr;
  logic [31:0] dm_wr_data;
  logic [31:0] dm_rd_data;
  logic        dm_done;
  logic        dm_stall;
  logic [1:0]  mem_command;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic [1:0]  dbg_state;

  mem_arbiter #(.MEM_LATENCY(L), .MAX_D_STREAK(MAXD)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_command(dm_command), .dm_addr(dm_addr), .dm_wr_data(dm_wr_data),
    .dm_rd_data(dm_rd_data), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_command(mem_command), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: at most one transaction in flight, finishing L cycles after issue.
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_kind = 0;   // 0 fetch, 1 load, 2 store
  int          m_issue = 0;
  int          m_streak = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  bit          x_ifv, x_dmd;

  logic [31:0] grant_log[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step();
    logic [1:0]  e_cmd;
    logic [31:0] e_addr, e_wd, e_ifd, e_dmd;
    bit e_ifv, e_dmdn, e_ifs, e_dms, g_d, g_i, fin, dpend;
    mem_rd_data = $urandom;
    @(negedge clk);
    dpend = (dm_command == 2'd1) || (dm_command == 2'd2);
    e_cmd = 0; e_addr = m_addr; e_wd = m_wdata; e_ifd = 0; e_dmd = 0;
    e_ifv = 0; e_dmdn = 0; g_d = 0; g_i = 0; fin = 0;
    if (rst) begin
      e_addr = 0; e_wd = 0;
    end else if (!m_busy) begin
      g_d = dpend && !(if_req && m_streak == MAXD);
      g_i = if_req && !g_d;
      if (g_d) begin
        e_cmd = dm_command; e_addr = dm_addr; e_wd = dm_wr_data;
      end else if (g_i) begin
        e_cmd = 2'd1; e_addr = if_addr; e_wd = 0;
      end
    end else begin
      fin    = (cyc == m_issue + L);
      e_ifv  = fin && (m_kind == 0);
      e_dmdn = fin && (m_kind != 0);
      e_ifd  = e_ifv ? mem_rd_data : 0;
      e_dmd  = (e_dmdn && m_kind == 1) ? mem_rd_data : 0;
    end
    e_ifs = !rst && if_req && !e_ifv;
    e_dms = !rst && dpend && !e_dmdn;

    chk("mem_command", 32'(mem_command), 32'(e_cmd));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wr_data", mem_wr_data, e_wd);
    chk("if_valid", 32'(if_valid), 32'(e_ifv));
    chk("if_data", if_data, e_ifd);
    chk("if_stall", 32'(if_stall), 32'(e_ifs));
    chk("dm_done", 32'(dm_done), 32'(e_dmdn));
    chk("dm_rd_data", dm_rd_data, e_dmd);
    chk("dm_stall", 32'(dm_stall), 32'(e_dms));
    if (mem_command != 2'd0) grant_log.push_back(mem_addr);

    if (rst) begin
      m_busy = 0; m_streak = 0; m_addr = 0; m_wdata = 0;
    end else begin
      if (fin) m_busy = 0;
      if (g_d || g_i) begin
        m_busy  = 1;
        m_issue = cyc;
        m_kind  = g_i ? 0 : int'(dm_command);
        m_addr  = e_addr;
        m_wdata = e_wd;
        if (g_i || !if_req) m_streak = 0;
        else if (m_streak < MAXD) m_streak++;
      end
    end
    x_ifv = e_ifv;
    x_dmd = e_dmdn;
    cyc++;
    @(posedge clk);
    #1;
    // Requesters retire their request once they see it completed.
    if (x_ifv) if_req = 0;
    if (x_dmd) dm_command = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1; if_req = 0; if_addr = 0; dm_command = 0; dm_addr = 0;
    dm_wr_data = 0; mem_rd_data = 0;
    @(posedge clk); #1;
    steps(2);
    rst = 0;

    // Lone fetch.
    if_req = 1; if_addr = 32'h100;
    steps(4);

    // Simultaneous fetch and load: data first, fetch issued after.
    if_req = 1; if_addr = 32'h104; dm_command = 2'd1; dm_addr = 32'h200;
    steps(7);

    // Store.
    dm_command = 2'd2; dm_addr = 32'h300; dm_wr_data = 32'hDEADBEEF;
    steps(4);

    // Starvation guard: fetch gets the fifth grant.
    grant_log.delete();
    for (int i = 0; i < 18; i++) begin
      if_req = 1; if_addr = 32'h1000;
      if (dm_command == 2'd0) begin dm_command = 2'd1; dm_addr = 32'h2000; end
      step();
    end
    exp_q = {32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000, 32'h2000};
    chk("grant_count", 32'(grant_log.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("grant_seq[%0d]", i), (i < grant_log.size()) ? grant_log[i] : 32'hx, exp_q[i]);
    if_req = 0; dm_command = 0;
    steps(3);

    // Reset in the middle of a fetch, new fetch right after release.
    if_req = 1; if_addr = 32'h400;
    step();
    rst = 1;
    step();
    rst = 0; if_addr = 32'h404;
    steps(4);

    // Reserved command value is ignored.
    dm_command = 2'd3; if_req = 0; dm_addr = 32'h500;
    steps(3);
    dm_command = 0;

    // Random traffic with withdrawals, address churn and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (!if_req) if_req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 15) == 0) if_req = 0;
      if (dm_command != 2'd1 && dm_command != 2'd2) dm_command = 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 15) == 0) dm_command = 0;
      if_addr    = $urandom;
      dm_addr    = $urandom;
      dm_wr_data = $urandom;
      rst        = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
